// File: rtl/dma_port_arbiter.sv
// Round-robin arbiter granting NREQ DMA requesters single-halfword reads
// on the shared memory port, only in cycles the CPU leaves the port idle.
module dma_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slot_free,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*16-1:0] req_addr,
  output logic [NREQ-1:0]    ack,
  output logic [15:0]        rd_data,
  output logic               mem_en,
  output logic [14:0]        mem_addr,
  input  logic [31:0]        mem_rdata,
  output logic               busy
);

  localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] next_ptr;
  logic          grant_found;
  logic [15:0]   addr_q;
  logic [1:0]    lat_cnt;
  logic [15:0]   addr_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[16*g +: 16];
  end

  // Scan from the rr pointer upward, wrapping, and take the first request.
  always_comb begin
    int unsigned j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= NR) j = j - NR;
      if (!grant_found && req[IW'(j)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

  assign next_ptr = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;

  assign mem_en   = (state == ISSUE) && slot_free;
  assign mem_addr = mem_en ? addr_q[15:1] : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      idx     <= '0;
      addr_q  <= '0;
      lat_cnt <= '0;
      ack     <= '0;
      rd_data <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            idx    <= grant_idx;
            addr_q <= addr_arr[grant_idx];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (slot_free) begin
            lat_cnt <= 2'(RD_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            rd_data <= addr_q[0] ? mem_rdata[31:16] : mem_rdata[15:0];
            ack     <= NREQ'(1) << idx;
            state   <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_en_in_issue: assert property (@(posedge clk) disable iff (rst) mem_en |-> state == ISSUE);

endmodule

// File: tb/tb_dma_port_arbiter.sv
// Directed bench for dma_port_arbiter: latency, round-robin order, stall,
// RD_LAT=3 capture timing, mid-transaction reset and address latching.
module tb_dma_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        slot_free = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_addr = '0;
  logic [3:0]  ack;
  logic [15:0] rd_data;
  logic        mem_en;
  logic [14:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        slot_free3 = 1'b1;
  logic [3:0]  req3 = '0;
  logic [63:0] req_addr3 = '0;
  logic [3:0]  ack3;
  logic [15:0] rd_data3;
  logic        mem_en3;
  logic [14:0] mem_addr3;
  logic [31:0] mem_rdata3;
  logic        busy3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_port_arbiter #(.NREQ(4), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .slot_free(slot_free), .req(req), .req_addr(req_addr),
    .ack(ack), .rd_data(rd_data), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dma_port_arbiter #(.NREQ(4), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .slot_free(slot_free3), .req(req3), .req_addr(req_addr3),
    .ack(ack3), .rd_data(rd_data3), .mem_en(mem_en3), .mem_addr(mem_addr3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory for the RD_LAT=1 instance: word 2 holds 0xBEEF1234, any other
  // word a holds {1,a,0,a}; all-ones outside the valid cycle.
  function automatic logic [31:0] word(input logic [14:0] a);
    if (a == 15'd2) return 32'hBEEF_1234;
    return {1'b1, a, 1'b0, a};
  endfunction

  logic        v1 = 1'b0;
  logic [14:0] a1 = '0;
  always @(posedge clk) begin
    v1 <= mem_en;
    a1 <= mem_addr;
  end
  assign mem_rdata = v1 ? word(a1) : 32'hFFFF_FFFF;

  logic [2:0] v3 = '0;
  always @(posedge clk) v3 <= {v3[1:0], mem_en3};
  assign mem_rdata3 = v3[2] ? 32'h1234_5678 : 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [3:0] a, output logic [15:0] d);
    a = '0;
    d = '0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        a = ack;
        d = rd_data;
        return;
      end
    end
    check("ack_seen", 32'(ack != '0), 32'd1);
  endtask

  logic [3:0]  ga;
  logic [15:0] gd;
  logic [3:0]  acc;
  logic [15:0] rr_rd [4] = '{16'h0020, 16'h8020, 16'h0021, 16'h8021};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;

    // 1: single request, exact latency
    tick();
    req = 4'b0001;
    req_addr[15:0] = 16'h0005;
    @(negedge clk);
    check("t1_c0_busy", 32'(busy), 32'h0);
    tick();
    @(negedge clk);
    check("t1_c1_mem_en", 32'(mem_en), 32'h1);
    check("t1_c1_mem_addr", 32'(mem_addr), 32'h0002);
    tick();
    @(negedge clk);
    check("t1_c2_ack", 32'(ack), 32'h0);
    tick();
    @(negedge clk);
    check("t1_c3_ack", 32'(ack), 32'h1);
    check("t1_rd_data", 32'(rd_data), 32'hBEEF);
    tick();
    req = '0;
    check("t1_mem_addr_idle", 32'(mem_addr), 32'h0);

    // 2: round-robin from reset, then wrap
    rst = 1'b1;
    req = 4'b1111;
    req_addr = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(ga, gd);
      check("rr_grant", 32'(ga), 32'(4'b0001 << k));
      check("rr_data", 32'(gd), 32'(rr_rd[k]));
      tick();
      req = req & ~ga;
    end
    req = 4'b1001;
    wait_ack(ga, gd);
    check("rr_wrap_first", 32'(ga), 32'h1);
    check("rr_wrap_first_data", 32'(gd), 32'h0020);
    tick();
    req = req & ~ga;
    wait_ack(ga, gd);
    check("rr_wrap_second", 32'(ga), 32'h8);
    check("rr_wrap_second_data", 32'(gd), 32'h8021);
    tick();
    req = '0;

    // 3: stall in ISSUE while slot_free is low
    tick();
    slot_free = 1'b0;
    req = 4'b0010;
    req_addr[31:16] = 16'h0010;
    for (int i = 1; i <= 10; i++) begin
      tick();
      @(negedge clk);
      check("stall_mem_en", 32'(mem_en), 32'h0);
      check("stall_busy", 32'(busy), 32'h1);
    end
    check("stall_mem_addr", 32'(mem_addr), 32'h0);
    tick();
    slot_free = 1'b1;
    @(negedge clk);
    check("stall_release_en", 32'(mem_en), 32'h1);
    check("stall_release_addr", 32'(mem_addr), 32'h0008);
    tick();
    @(negedge clk);
    check("stall_ack_early", 32'(ack), 32'h0);
    tick();
    @(negedge clk);
    check("stall_ack", 32'(ack), 32'h2);
    check("stall_rd_data", 32'(rd_data), 32'h0008);
    tick();
    req = '0;

    // 6: address latched at grant
    tick();
    req = 4'b0010;
    req_addr[31:16] = 16'h0010;
    tick();
    req_addr[31:16] = 16'h0020;
    @(negedge clk);
    check("latch_mem_en", 32'(mem_en), 32'h1);
    check("latch_mem_addr", 32'(mem_addr), 32'h0008);
    wait_ack(ga, gd);
    check("latch_ack", 32'(ga), 32'h2);
    check("latch_rd_data", 32'(gd), 32'h0008);
    tick();
    req = '0;

    // 5: reset in WAIT aborts; rr pointer (currently 2) restarts at 0
    tick();
    req = 4'b0001;
    req_addr[15:0] = 16'h0005;
    tick();
    @(negedge clk);
    check("abort_inflight", 32'(mem_en), 32'h1);
    tick();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("abort_ack", 32'(ack), 32'h0);
    check("abort_rd_data", 32'(rd_data), 32'h0);
    check("abort_mem_en", 32'(mem_en), 32'h0);
    check("abort_mem_addr", 32'(mem_addr), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    acc = '0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      acc = acc | ack;
    end
    check("abort_no_ack", 32'(acc), 32'h0);
    check("abort_rd_kept_zero", 32'(rd_data), 32'h0);
    tick();
    req = 4'b1010;
    req_addr[31:16] = 16'h0011;
    req_addr[63:48] = 16'h0030;
    wait_ack(ga, gd);
    check("ptr_reset_first", 32'(ga), 32'h2);
    check("ptr_reset_first_data", 32'(gd), 32'h8008);
    tick();
    req = req & ~ga;
    wait_ack(ga, gd);
    check("ptr_reset_second", 32'(ga), 32'h8);
    check("ptr_reset_second_data", 32'(gd), 32'h0018);
    tick();
    req = 4'b0100;
    req_addr[47:32] = 16'h0007;
    wait_ack(ga, gd);
    check("after_rst_req2", 32'(ga), 32'h4);
    check("after_rst_req2_data", 32'(gd), 32'h8003);
    tick();
    req = '0;

    // 4: RD_LAT=3 instance, capture exactly 3 cycles after issue
    tick();
    req3 = 4'b0001;
    req_addr3[15:0] = 16'h0000;
    tick();
    @(negedge clk);
    check("lat3_mem_en", 32'(mem_en3), 32'h1);
    check("lat3_mem_addr", 32'(mem_addr3), 32'h0);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("lat3_ack_early", 32'(ack3), 32'h0);
    check("lat3_busy", 32'(busy3), 32'h1);
    tick();
    @(negedge clk);
    check("lat3_ack", 32'(ack3), 32'h1);
    check("lat3_rd_data", 32'(rd_data3), 32'h5678);
    tick();
    req3 = '0;
    @(negedge clk);
    check("lat3_ack_pulse", 32'(ack3), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
